mem_access_sequencer: RTL and testbench

Sequences the CPU's single-port 16-bit memory bus between two requesters: instruction fetch (PC-addressed) and data load/store (MAR-addressed). It arbitrates with data priority and a bounded fetch-starvation guard. It drives the memory address, write data and strobes for a fixed number of wait states, then returns read data and a one-cycle acknowledge to the granted requester. It sits between the control unit/PC/MAR and the memory, and replaces static address selection with a handshaked, multi-cycle access sequence.

---
 rtl/mem_access_sequencer.sv | 139 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Shares the single-port 16-bit memory bus between instruction fetch and data load/store.
// Data requests win arbitration, but fetch is forced in after STARVE_LIMIT consecutive data grants.
module mem_access_sequencer #(
  parameter int WAIT_STATES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        grant_data
);

  localparam logic [3:0] LP_WAIT_LAST    = 4'(WAIT_STATES);
  localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_waitCnt;
  logic [3:0] r_starveCnt;
  logic       r_we;
  logic       w_grant;
  logic       w_grantData;
  logic       w_lastBeat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Arbitration, sequencing and all strobe/ack outputs are decoded from the state.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantData = 1'b0;
    w_lastBeat  = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (d_req && !(if_req && (r_starveCnt >= LP_STARVE_LIMIT))) begin
          w_grant     = 1'b1;
          w_grantData = 1'b1;
        end else if (if_req) begin
          w_grant     = 1'b1;
          w_grantData = 1'b0;
        end
        if (w_grant) begin
          w_nextState = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy       = 1'b1;
        mem_re     = !r_we;
        mem_we     = r_we;
        w_lastBeat = (r_waitCnt == LP_WAIT_LAST);
        if (w_lastBeat) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        busy        = 1'b1;
        if_ack      = !grant_data;
        d_ack       = grant_data;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Latched request, wait-state counter, starvation counter and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_waitCnt   <= '0;
      r_starveCnt <= '0;
      r_we        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant_data  <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      if (w_grant) begin
        r_waitCnt  <= '0;
        grant_data <= w_grantData;
        r_we       <= w_grantData && d_we;
        mem_addr   <= w_grantData ? d_addr : if_addr;
        if (w_grantData) begin
          mem_wdata <= d_wdata;
        end
        if (w_grantData && if_req) begin
          r_starveCnt <= r_starveCnt + 4'd1;
        end else begin
          r_starveCnt <= '0;
        end
      end
      if (r_state == ST_ACCESS) begin
        if (!w_lastBeat) begin
          r_waitCnt <= r_waitCnt + 4'd1;
        end else if (!r_we) begin
          if (grant_data) begin
            d_rdata <= mem_rdata;
          end else begin
            if_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: directed fetch/load/store vectors on a
// WAIT_STATES=2 instance plus back-to-back loads on a WAIT_STATES=0 instance.
module tb_mem_access_sequencer;

  typedef struct {
    bit          isData;
    bit          isStore;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expIf;
    logic [15:0] expD;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        ifReq, ifAck, dReq, dWe, dAck, memRe, memWe, busy, grantData;
  logic [15:0] ifAddr, ifRdata, dAddr, dWdata, dRdata, memAddr, memWdata, memRdata;

  logic        zIfReq, zIfAck, zDReq, zDWe, zDAck, zMemRe, zMemWe, zBusy, zGrantData;
  logic [15:0] zIfAddr, zIfRdata, zDAddr, zDWdata, zDRdata, zMemAddr, zMemWdata, zMemRdata;

  int          total = 0;
  int          bad = 0;
  exp_t        sbq[$];
  exp_t        zq[$];
  logic [15:0] expIf, expD;
  bit          monitorOn;
  int          strobeCnt = 0;
  int          sinceAck = 0;
  int          zStrobeCnt = 0;
  int          zSinceAck = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memModel(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hC3C3);
  endfunction

  assign memRdata  = memModel(memAddr);
  assign zMemRdata = memModel(zMemAddr);

  mem_access_sequencer #(.WAIT_STATES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(resetN),
    .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAck), .if_rdata(ifRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_ack(dAck), .d_rdata(dRdata),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_re(memRe), .mem_we(memWe),
    .mem_rdata(memRdata), .busy(busy), .grant_data(grantData)
  );

  mem_access_sequencer #(.WAIT_STATES(0), .STARVE_LIMIT(4)) dutZero (
    .clk(clk), .reset_n(resetN),
    .if_req(zIfReq), .if_addr(zIfAddr), .if_ack(zIfAck), .if_rdata(zIfRdata),
    .d_req(zDReq), .d_we(zDWe), .d_addr(zDAddr), .d_wdata(zDWdata),
    .d_ack(zDAck), .d_rdata(zDRdata),
    .mem_addr(zMemAddr), .mem_wdata(zMemWdata), .mem_re(zMemRe), .mem_we(zMemWe),
    .mem_rdata(zMemRdata), .busy(zBusy), .grant_data(zGrantData)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected responses are pushed in the order the arbiter must serve them.
  task automatic pushExp(input bit isData, input bit isStore, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int gap);
    exp_t e;
    if (!isData) expIf = rdata;
    else if (!isStore) expD = rdata;
    e.isData = isData; e.isStore = isStore; e.addr = addr; e.wdata = wdata;
    e.expIf = expIf; e.expD = expD; e.gap = gap;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input bit isFetch, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata, input bit keepHigh, input int expLat);
    int  n;
    bit  seen;
    if (isFetch) begin
      ifReq = 1'b1; ifAddr = addr;
    end else begin
      dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
    end
    seen = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (isFetch ? ifAck : dAck) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput(isFetch ? "fetch_ack_timeout" : "data_ack_timeout", 32'd0, 32'd1);
    else if (expLat != 0) checkOutput("ack_latency", n, expLat);
    @(posedge clk); #1;
    if (!keepHigh) begin
      if (isFetch) ifReq = 1'b0;
      else dReq = 1'b0;
    end
  endtask

  task automatic zLoad(input logic [15:0] addr, input logic [15:0] rdata, input int gap,
                       input bit keepHigh, input int expLat);
    exp_t e;
    int   n;
    bit   seen;
    e.isData = 1'b1; e.isStore = 1'b0; e.addr = addr; e.wdata = 16'h0;
    e.expIf = 16'h0; e.expD = rdata; e.gap = gap;
    zq.push_back(e);
    zDReq = 1'b1; zDAddr = addr;
    seen = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (zDAck) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("z_ack_timeout", 32'd0, 32'd1);
    else if (expLat != 0) checkOutput("z_ack_latency", n, expLat);
    @(posedge clk); #1;
    if (!keepHigh) zDReq = 1'b0;
  endtask

  // Monitor for the WAIT_STATES=2 instance: strobes checked against the head entry, acks pop it.
  always @(negedge clk) begin
    exp_t e;
    if (!monitorOn) begin
      strobeCnt = 0;
      sinceAck  = 0;
    end else begin
      if (memRe || memWe) begin
        checkOutput("strobe_exclusive", 32'(memRe && memWe), 32'd0);
        if (sbq.size() == 0) begin
          checkOutput("strobe_unexpected", 32'd1, 32'd0);
        end else begin
          if (strobeCnt == 0 && sbq[0].gap != 0) checkOutput("idle_gap", sinceAck, sbq[0].gap);
          checkOutput("mem_addr", memAddr, sbq[0].addr);
          checkOutput("mem_we", 32'(memWe), 32'(sbq[0].isStore));
          if (sbq[0].isStore) checkOutput("mem_wdata", memWdata, sbq[0].wdata);
          checkOutput("busy_access", 32'(busy), 32'd1);
        end
        strobeCnt++;
      end
      if (ifAck || dAck) begin
        if (sbq.size() == 0) begin
          checkOutput("ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("dual_ack", 32'(ifAck && dAck), 32'd0);
          checkOutput("ack_source", 32'(dAck), 32'(e.isData));
          checkOutput("grant_data", 32'(grantData), 32'(e.isData));
          checkOutput("strobe_width", strobeCnt, 32'd3);
          checkOutput("if_rdata", ifRdata, e.expIf);
          checkOutput("d_rdata", dRdata, e.expD);
        end
        strobeCnt = 0;
        sinceAck  = 0;
      end else begin
        sinceAck++;
      end
    end
  end

  // Monitor for the WAIT_STATES=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (zMemRe || zMemWe) begin
      if (zq.size() == 0) begin
        checkOutput("z_strobe_unexpected", 32'd1, 32'd0);
      end else begin
        if (zStrobeCnt == 0 && zq[0].gap != 0) checkOutput("z_idle_gap", zSinceAck, zq[0].gap);
        checkOutput("z_mem_addr", zMemAddr, zq[0].addr);
        checkOutput("z_mem_re", 32'(zMemRe), 32'd1);
      end
      zStrobeCnt++;
    end
    if (zDAck || zIfAck) begin
      if (zq.size() == 0) begin
        checkOutput("z_ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = zq.pop_front();
        checkOutput("z_ack_source", 32'(zDAck), 32'd1);
        checkOutput("z_strobe_width", zStrobeCnt, 32'd1);
        checkOutput("z_d_rdata", zDRdata, e.expD);
      end
      zStrobeCnt = 0;
      zSinceAck  = 0;
    end else begin
      zSinceAck++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int acks;
    resetN = 1'b0; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    zIfReq = 1'b0; zIfAddr = '0; zDReq = 1'b0; zDWe = 1'b0; zDAddr = '0; zDWdata = '0;
    monitorOn = 1'b1; expIf = '0; expD = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_acks", {30'd0, ifAck, dAck}, 32'd0);
    checkOutput("rst_strobes", {30'd0, memRe, memWe}, 32'd0);
    checkOutput("rst_busy_grant", {30'd0, busy, grantData}, 32'd0);
    checkOutput("rst_mem_addr", memAddr, 32'd0);
    checkOutput("rst_mem_wdata", memWdata, 32'd0);
    checkOutput("rst_rdata", {ifRdata, dRdata}, 32'd0);
    @(posedge clk); #1 resetN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single fetch");
    pushExp(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 5);
    repeat (2) @(posedge clk); #1;

    $display("[TB] store then load");
    pushExp(1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'h0000, 0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 16'hA5A5, 1'b0, 5);
    pushExp(1'b1, 1'b0, 16'h2000, 16'h0000, 16'hE3C3, 0);
    applyStimulus(1'b0, 1'b0, 16'h2000, 16'h0000, 1'b0, 5);
    repeat (2) @(posedge clk); #1;

    $display("[TB] simultaneous requests");
    pushExp(1'b1, 1'b0, 16'h0300, 16'h0000, 16'hC0C3, 0);
    pushExp(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hC383, 1);
    fork
      applyStimulus(1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 0);
    join
    repeat (2) @(posedge clk); #1;

    $display("[TB] fetch starvation guard");
    pushExp(1'b1, 1'b0, 16'h0101, 16'h0000, 16'hC2C2, 0);
    pushExp(1'b1, 1'b1, 16'h0102, 16'h1111, 16'h0000, 1);
    pushExp(1'b1, 1'b0, 16'h0103, 16'h0000, 16'hC2C0, 1);
    pushExp(1'b1, 1'b0, 16'h0104, 16'h0000, 16'hC2C7, 1);
    pushExp(1'b0, 1'b0, 16'h0050, 16'h0000, 16'hC393, 1);
    pushExp(1'b1, 1'b0, 16'h0105, 16'h0000, 16'hC2C6, 1);
    fork
      begin
        applyStimulus(1'b0, 1'b0, 16'h0101, 16'h0000, 1'b1, 5);
        applyStimulus(1'b0, 1'b1, 16'h0102, 16'h1111, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 16'h0103, 16'h0000, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 16'h0104, 16'h0000, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 16'h0105, 16'h0000, 1'b0, 0);
      end
      applyStimulus(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 0);
    join
    repeat (2) @(posedge clk); #1;

    $display("[TB] reset during store");
    monitorOn = 1'b0;
    dReq = 1'b1; dWe = 1'b1; dAddr = 16'h4444; dWdata = 16'h5A5A;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memWe) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("abort_store_started", 32'(seen), 32'd1);
    #2 resetN = 1'b0;
    dReq = 1'b0;
    #1;
    checkOutput("abort_mem_we", 32'(memWe), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mem_addr", memAddr, 32'd0);
    checkOutput("abort_rdata", {ifRdata, dRdata}, 32'd0);
    @(posedge clk); #1 resetN = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (dAck || ifAck) acks++;
    end
    checkOutput("abort_no_ack", acks, 32'd0);
    expIf = '0; expD = '0;
    monitorOn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] fetch after reset");
    pushExp(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 5);
    repeat (2) @(posedge clk); #1;

    $display("[TB] zero wait states, back-to-back loads");
    zLoad(16'h0A00, 16'hC9C3, 0, 1'b1, 3);
    zLoad(16'h0A01, 16'hC9C2, 1, 1'b0, 0);

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", sbq.size(), 32'd0);
    checkOutput("z_sb_drained", zq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
